// File: rtl/stream_edge_pkg.sv
// Shared types and helpers for the multi-channel stream edge detector.
// Mode encoding per channel and the width helper for the debounce counter.
package stream_edge_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    // Bits needed to hold values 0..depth-1, never less than one bit.
    function automatic int clog2_min1(input int depth);
        int w;
        for (w = 1; (1 << w) < depth; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One input stream: synchroniser, debounce filter, edge qualification,
// saturating event counter and sticky flag.
module edge_channel
    import stream_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             stream_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             out_o,
    output logic             level_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               DEB_W    = clog2_min1(DEBOUNCE);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   level_q, level_d;
    logic                   out_q, out_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic  synced;
    logic  mismatch;
    logic  toggle;
    logic  hit;
    mode_t mode_sel;

    assign mode_sel = mode_t'(mode_i);
    assign synced   = sync_q[SYNC_STAGES-1];
    assign mismatch = (synced != level_q);
    // The level flips on the DEBOUNCE-th consecutive mismatching sample.
    assign toggle   = mismatch && (deb_cnt_q == DEB_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        sync_d    = {sync_q[SYNC_STAGES-2:0], stream_i};
        deb_cnt_d = '0;
        level_d   = level_q;
        hit       = 1'b0;

        if (toggle) begin
            level_d = ~level_q;
        end else if (mismatch) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end

        case (mode_sel)
            MODE_RISE: hit = toggle && !level_q;
            MODE_FALL: hit = toggle &&  level_q;
            MODE_BOTH: hit = toggle;
            default:   hit = 1'b0;
        endcase

        out_d = hit;

        // Clear first, then let a same-cycle event count on top of it.
        count_d = clr_i ? '0 : count_q;
        if (hit && (count_d != CNT_MAX)) begin
            count_d = count_d + 1'b1;
        end
        sticky_d = (sticky_q && !clr_i) || hit;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            out_q     <= 1'b0;
            sticky_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            out_q     <= out_d;
            sticky_q  <= sticky_d;
            count_q   <= count_d;
        end
    end

    assign out_o    = out_q;
    assign level_o  = level_q;
    assign sticky_o = sticky_q;
    assign count_o  = count_q;

endmodule

// File: rtl/stream_edge_detector.sv
// Multi-channel debounced edge detector: one edge_channel per input stream
// plus a combinational any-event summary of the registered pulses.
module stream_edge_detector
    import stream_edge_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [CHANNELS-1:0]       stream,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic                      clr,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       sticky,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic                      any_event
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE),
            .CNT_W      (CNT_W)
        ) u_ch (
            .sys_clk  (sys_clk),
            .sys_rst_n(sys_rst_n),
            .stream_i (stream[c]),
            .mode_i   (mode[2*c +: 2]),
            .clr_i    (clr),
            .out_o    (out[c]),
            .level_o  (level[c]),
            .sticky_o (sticky[c]),
            .count_o  (count[c*CNT_W +: CNT_W])
        );
    end

    assign any_event = |out;

endmodule
